// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - MIDI status types, controller numbers and decoder state encoding
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CTRL     = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PBEND    = 4'hE;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_D1 = 2'd1;
    localparam logic [1:0] WAIT_D2 = 2'd2;

    // Program change and channel aftertouch carry one data byte; all other channel messages carry two.
    function automatic logic [1:0] msg_len(input logic [3:0] msg_type);
        return ((msg_type == PROG) || (msg_type == CH_AT)) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// rtl/midi_note_decoder_if.sv - byte input and note event outputs of the MIDI note decoder
interface midi_note_decoder_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic [3:0] channel;
    logic       note_on;
    logic       note_off;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       all_notes_off;
    logic       msg_error;

    modport master (
        output byte_valid, byte_data, channel,
        input  note_on, note_off, note, velocity, all_notes_off, msg_error
    );

    modport slave (
        input  byte_valid, byte_data, channel,
        output note_on, note_off, note, velocity, all_notes_off, msg_error
    );

endinterface

// File: rtl/midi_byte_classify.sv
// rtl/midi_byte_classify.sv - combinational classification of a received MIDI byte
import midi_pkg::*;

module midi_byte_classify (
    input  logic [7:0] byte_data,
    output logic       is_realtime,
    output logic       is_syscommon,
    output logic       is_status,
    output logic       is_data,
    output logic [1:0] data_len
);

    assign is_realtime  = (byte_data[7:3] == 5'b11111);
    assign is_syscommon = (byte_data[7:3] == 5'b11110);
    assign is_status    = byte_data[7] && (byte_data[7:4] != 4'hF);
    assign is_data      = ~byte_data[7];
    assign data_len     = msg_len(byte_data[7:4]);

endmodule

// File: rtl/midi_note_decoder.sv
// rtl/midi_note_decoder.sv - MIDI byte stream to note_on/note_off/all_notes_off strobes
import midi_pkg::*;

module midi_note_decoder #(
    parameter bit OMNI = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    midi_note_decoder_if.slave   bus
);

    logic       is_realtime;
    logic       is_syscommon;
    logic       is_status;
    logic       is_data;
    logic [1:0] data_len;

    logic [1:0] state;
    logic [3:0] msg_type;
    logic       two_byte;
    logic       match;
    logic       fresh;
    logic [6:0] d1;

    logic       note_on_q;
    logic       note_off_q;
    logic       all_notes_off_q;
    logic       msg_error_q;
    logic [6:0] note_q;
    logic [6:0] velocity_q;

    midi_byte_classify u_classify (
        .byte_data    (bus.byte_data),
        .is_realtime  (is_realtime),
        .is_syscommon (is_syscommon),
        .is_status    (is_status),
        .is_data      (is_data),
        .data_len     (data_len)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            msg_type        <= 4'h0;
            two_byte        <= 1'b0;
            match           <= 1'b0;
            fresh           <= 1'b0;
            d1              <= 7'd0;
            note_on_q       <= 1'b0;
            note_off_q      <= 1'b0;
            all_notes_off_q <= 1'b0;
            msg_error_q     <= 1'b0;
            note_q          <= 7'd0;
            velocity_q      <= 7'd0;
        end else begin
            note_on_q       <= 1'b0;
            note_off_q      <= 1'b0;
            all_notes_off_q <= 1'b0;
            msg_error_q     <= 1'b0;
            if (bus.byte_valid) begin
                if (is_realtime) begin
                    // Real-time bytes may sit inside a message and must leave it intact.
                end else if (is_syscommon) begin
                    state <= IDLE;
                    fresh <= 1'b0;
                end else if (is_status) begin
                    // fresh marks WAIT_D1 entered from a status byte, as opposed to running status.
                    msg_error_q <= (state == WAIT_D2) || ((state == WAIT_D1) && fresh);
                    msg_type    <= bus.byte_data[7:4];
                    two_byte    <= (data_len == 2'd2);
                    match       <= OMNI || (bus.byte_data[3:0] == bus.channel);
                    state       <= WAIT_D1;
                    fresh       <= 1'b1;
                end else if (is_data) begin
                    case (state)
                        WAIT_D1: begin
                            d1 <= bus.byte_data[6:0];
                            if (two_byte) begin
                                state <= WAIT_D2;
                            end else begin
                                fresh <= 1'b0;
                            end
                        end
                        WAIT_D2: begin
                            state <= WAIT_D1;
                            fresh <= 1'b0;
                            if (match) begin
                                if (msg_type == NOTE_ON && bus.byte_data[6:0] != 7'd0) begin
                                    note_on_q  <= 1'b1;
                                    note_q     <= d1;
                                    velocity_q <= bus.byte_data[6:0];
                                end else if (msg_type == NOTE_ON || msg_type == NOTE_OFF) begin
                                    note_off_q <= 1'b1;
                                    note_q     <= d1;
                                    velocity_q <= bus.byte_data[6:0];
                                end else if (msg_type == CTRL && d1 == CC_ALL_NOTES_OFF) begin
                                    all_notes_off_q <= 1'b1;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign bus.note_on       = note_on_q;
    assign bus.note_off      = note_off_q;
    assign bus.all_notes_off = all_notes_off_q;
    assign bus.msg_error     = msg_error_q;
    assign bus.note          = note_q;
    assign bus.velocity      = velocity_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// tb/tb_midi_note_decoder.sv - directed self-checking bench for midi_note_decoder, OMNI off and on
module tb_midi_note_decoder;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    midi_note_decoder_if bus0 ();
    midi_note_decoder_if bus1 ();

    midi_note_decoder #(.OMNI(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    midi_note_decoder #(.OMNI(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {note_on, note_off, all_notes_off, msg_error, note, velocity}
    function automatic logic [17:0] pk(input logic on, input logic off, input logic ano,
                                       input logic err, input logic [6:0] n, input logic [6:0] v);
        return {on, off, ano, err, n, v};
    endfunction

    task automatic chk2(input string tag, input logic [17:0] exp0, input logic [17:0] exp1);
        logic [17:0] obs0;
        logic [17:0] obs1;
        obs0 = {bus0.note_on, bus0.note_off, bus0.all_notes_off, bus0.msg_error, bus0.note, bus0.velocity};
        obs1 = {bus1.note_on, bus1.note_off, bus1.all_notes_off, bus1.msg_error, bus1.note, bus1.velocity};
        tests++;
        assert (obs0 === exp0) else begin
            fails++;
            $error("FAIL %s omni0 observed %h expected %h", tag, obs0, exp0);
        end
        tests++;
        assert (obs1 === exp1) else begin
            fails++;
            $error("FAIL %s omni1 observed %h expected %h", tag, obs1, exp1);
        end
    endtask

    task automatic chk(input string tag, input logic [17:0] exp);
        chk2(tag, exp, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        bus0.byte_valid = v;
        bus1.byte_valid = v;
        bus0.byte_data  = b;
        bus1.byte_data  = b;
    endtask

    task automatic set_channel(input logic [3:0] c);
        bus0.channel = c;
        bus1.channel = c;
    endtask

    // Presents one byte for one cycle; returns in the cycle where its strobe would be visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        drive(1'b1, b);
        @(negedge clk);
        drive(1'b0, 8'h00);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive(1'b0, 8'h00);
        set_channel(4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset", pk(0, 0, 0, 0, 7'd0, 7'd0));

        send(8'h90); chk("on_status", pk(0, 0, 0, 0, 7'd0, 7'd0));
        send(8'h3C); chk("on_d1", pk(0, 0, 0, 0, 7'd0, 7'd0));
        send(8'h64); chk("on_basic", pk(1, 0, 0, 0, 7'd60, 7'd100));
        @(negedge clk); chk("on_one_cycle", pk(0, 0, 0, 0, 7'd60, 7'd100));

        send(8'h40); chk("rs_d1", pk(0, 0, 0, 0, 7'd60, 7'd100));
        send(8'h50); chk("rs_on", pk(1, 0, 0, 0, 7'd64, 7'd80));
        send(8'h3C);
        send(8'h00); chk("rs_vel0_off", pk(0, 1, 0, 0, 7'd60, 7'd0));

        set_channel(4'd2);
        send(8'h91);
        send(8'h3C);
        send(8'h64); chk2("chan_filter", pk(0, 0, 0, 0, 7'd60, 7'd0), pk(1, 0, 0, 0, 7'd60, 7'd100));

        set_channel(4'd0);
        send(8'h90);
        send(8'hF8); chk2("rt_in_msg", pk(0, 0, 0, 0, 7'd60, 7'd0), pk(0, 0, 0, 0, 7'd60, 7'd100));
        send(8'h3C);
        send(8'hFE);
        send(8'h64); chk("rt_interleave_on", pk(1, 0, 0, 0, 7'd60, 7'd100));
        send(8'hB0);
        send(8'h7B);
        send(8'h00); chk("all_notes_off", pk(0, 0, 1, 0, 7'd60, 7'd100));

        send(8'h90);
        send(8'h3C);
        send(8'h80); chk("abandon_err", pk(0, 0, 0, 1, 7'd60, 7'd100));
        send(8'h3C);
        send(8'h40); chk("note_off_vel", pk(0, 1, 0, 0, 7'd60, 7'd64));
        send(8'hC0); chk("prog_status_no_err", pk(0, 0, 0, 0, 7'd60, 7'd64));
        send(8'h05); chk("prog_1", pk(0, 0, 0, 0, 7'd60, 7'd64));
        send(8'h07); chk("prog_2_running", pk(0, 0, 0, 0, 7'd60, 7'd64));

        send(8'h90);
        send(8'h3C);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_msg_reset", pk(0, 0, 0, 0, 7'd0, 7'd0));
        send(8'h64); chk("after_reset_data", pk(0, 0, 0, 0, 7'd0, 7'd0));
        send(8'h90);
        send(8'hF0);
        send(8'h3C);
        send(8'h64); chk("syscommon_clears", pk(0, 0, 0, 0, 7'd0, 7'd0));

        @(negedge clk); drive(1'b1, 8'h90);
        @(negedge clk); drive(1'b1, 8'h3C);
        @(negedge clk); drive(1'b1, 8'h64);
        @(negedge clk); drive(1'b0, 8'h00);
        chk("b2b_on", pk(1, 0, 0, 0, 7'd60, 7'd100));
        @(negedge clk); chk("b2b_cleared", pk(0, 0, 0, 0, 7'd60, 7'd100));

        send(8'h90);
        send(8'h90); chk("status_after_status_err", pk(0, 0, 0, 1, 7'd60, 7'd100));
        send(8'h45);
        send(8'h22); chk("on_after_err", pk(1, 0, 0, 0, 7'd69, 7'd34));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/midi_note_decoder.md
Name: midi_note_decoder

Overview:
- Upstream stage of the monophonic note-priority block: turns the byte stream from the MIDI UART receiver into single-cycle note_on/note_off strobes with a 7-bit note number and velocity.
- Handles running status, real-time bytes interleaved inside messages, channel filtering, note-on with velocity 0, and the All Notes Off controller.
- Its note_on, note_off and note outputs connect directly to the note_on, note_off and note inputs of the note-priority stage.
- Its all_notes_off output feeds that stage's rst through an OR with the system reset.

Parameters:
- OMNI, 0: when 1, accept all channels and ignore the channel port.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- byte_valid  in  1  single-cycle strobe; byte_data is valid this cycle
- byte_data  in  8  received MIDI byte
- channel  in  4  receive channel, 0..15 (MIDI channels 1..16); sampled when a status byte is accepted
- note_on  out  1  one-cycle strobe: note-on decoded
- note_off  out  1  one-cycle strobe: note-off decoded
- note  out  7  note number of the last note message; held between messages
- velocity  out  7  velocity of the last note message; held between messages
- all_notes_off  out  1  one-cycle strobe: controller 123 received on the matched channel
- msg_error  out  1  one-cycle strobe: a partial message was abandoned by a new status byte

Behaviour:
- Reset: state IDLE, running status cleared. All strobes are 0; note = 0, velocity = 0. A reset mid-message discards the partial message with no strobe.
- Bytes are processed only in cycles where byte_valid = 1. Other cycles change nothing except clearing strobes.
- Strobes are registered. They assert for exactly one cycle, the cycle after the byte completing a message is accepted (latency 1). note and velocity update in the same cycle as the strobe.
- Byte classes:
  - Real-time, 0xF8..0xFF: ignored completely. State, running status and partial data are untouched.
  - System common/exclusive, 0xF0..0xF7: clear running status and go to IDLE.
  - Channel status, 0x80..0xEF: store the type nibble and match flag (match = OMNI or low nibble == channel), then go to WAIT_D1.
  - Data, 0x00..0x7F: handled according to the state.
- Data length by type:
  - 0x8, 0x9, 0xA, 0xB, 0xE: 2 data bytes.
  - 0xC, 0xD: 1 data byte.
- States:
  - IDLE: data bytes are discarded.
  - WAIT_D1: on a data byte, latch it as d1. For 2-byte types go to WAIT_D2. For 1-byte types the message completes with no output, and the state returns to WAIT_D1 (running status).
  - WAIT_D2: on a data byte the message completes and the state returns to WAIT_D1 (running status).
- Actions on message completion, only when match = 1:
  - Type 0x9 with d2 != 0: note_on; note = d1, velocity = d2.
  - Type 0x9 with d2 == 0: note_off; note = d1, velocity = 0.
  - Type 0x8: note_off; note = d1, velocity = d2.
  - Type 0xB with d1 == 123: all_notes_off. note and velocity are unchanged.
  - Any other type, or match = 0: no strobe.
- A channel status byte arriving in WAIT_D2, or in WAIT_D1 with a pending partial: msg_error strobe, then the new status is taken. "Pending partial" excludes WAIT_D1 reached via running status.
- At most one of note_on, note_off, all_notes_off is high in any cycle.
- Back-to-back byte_valid on consecutive cycles is supported at full rate.

Decomposition:
- Package midi_pkg holds:
  - status-type constants: NOTE_OFF = 4'h8, NOTE_ON = 4'h9, POLY_AT = 4'hA, CTRL = 4'hB, PROG = 4'hC, CH_AT = 4'hD, PBEND = 4'hE;
  - CC_ALL_NOTES_OFF = 7'd123;
  - the state encoding IDLE/WAIT_D1/WAIT_D2.
- One sub-module, midi_byte_classify. It is combinational: from byte_data it produces is_realtime, is_syscommon, is_status, is_data and the data length (1 or 2). The FSM and output registers stay in the top.

Test Plan:
- Basic note-on: channel = 0, bytes 0x90, 0x3C, 0x64 → one note_on pulse the cycle after 0x64, note = 60, velocity = 100. No other strobes.
- Running status with velocity 0: after the above, send 0x40, 0x50 then 0x3C, 0x00 → note_on with note = 64, velocity = 80; then note_off with note = 60, velocity = 0.
- Channel filter: channel = 2, OMNI = 0, bytes 0x91, 0x3C, 0x64 → no strobes. Repeat with OMNI = 1 → note_on with note = 60.
- Real-time interleave and All Notes Off: bytes 0x90, 0xF8, 0x3C, 0xFE, 0x64 → note_on with note = 60. Then 0xB0, 0x7B, 0x00 → all_notes_off pulse; note stays 60.
- Abandon and 1-byte types: bytes 0x90, 0x3C, 0x80 → msg_error pulse; then 0x3C, 0x40 → note_off with note = 60, velocity = 64. Then 0xC0, 0x05, 0x07 → no strobes (two program changes via running status).
- Reset and system common: bytes 0x90, 0x3C, then rst for 1 cycle, then 0x64 → no strobe, note = 0. Bytes 0x90, 0xF0, 0x3C, 0x64 → no strobe (running status cleared).
